// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - 20-bit XNOR PRBS receive checker: hunt, sync, flywheel lock, error counting.
// Optional per-bit error counter enabled by defining LFSR_CHK_BITERR_EN.
module lfsr_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             in_valid,
    input  logic [19:0]      data_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
`ifdef LFSR_CHK_BITERR_EN
    output logic [ERR_W-1:0] bit_err_count,
`endif
    output logic [ERR_W-1:0] err_count
);

    localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int LW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
    localparam logic [19:0] LOCKUP = 20'hFFFFF;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic [19:0]      r_prev;
    logic [MW-1:0]    r_match_cnt;
    logic [LW-1:0]    r_miss_cnt;

    logic [19:0]      w_exp;
    logic             w_match;
    logic             w_lockup;
    logic [ERR_W-1:0] w_err_base;
    logic [ERR_W-1:0] w_err_inc;

    always_comb begin
        w_exp      = {r_prev[18:0], ~(r_prev[6] ^ r_prev[19])};
        w_match    = (data_in == w_exp);
        w_lockup   = (data_in == LOCKUP);
        // clear takes effect before a same-cycle error is added
        w_err_base = clear ? '0 : err_count;
        w_err_inc  = (&w_err_base) ? w_err_base : w_err_base + ERR_W'(1);
    end

`ifdef LFSR_CHK_BITERR_EN
    logic [19:0]      w_diff;
    logic [4:0]       w_popcnt;
    logic [ERR_W-1:0] w_bit_base;
    logic [ERR_W:0]   w_bit_sum;
    logic [ERR_W-1:0] w_bit_inc;

    always_comb begin
        w_diff   = data_in ^ w_exp;
        w_popcnt = '0;
        for (int i = 0; i < 20; i++) begin
            w_popcnt = w_popcnt + 5'(w_diff[i]);
        end
        w_bit_base = clear ? '0 : bit_err_count;
        w_bit_sum  = {1'b0, w_bit_base} + (ERR_W+1)'(w_popcnt);
        w_bit_inc  = w_bit_sum[ERR_W] ? '1 : w_bit_sum[ERR_W-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state       <= HUNT;
            r_prev        <= '0;
            r_match_cnt   <= '0;
            r_miss_cnt    <= '0;
            locked        <= 1'b0;
            err_pulse     <= 1'b0;
            err_count     <= '0;
`ifdef LFSR_CHK_BITERR_EN
            bit_err_count <= '0;
`endif
        end else begin
            err_pulse     <= 1'b0;
            err_count     <= w_err_base;
`ifdef LFSR_CHK_BITERR_EN
            bit_err_count <= w_bit_base;
`endif
            case (r_state)
                HUNT: begin
                    if (in_valid && !w_lockup) begin
                        r_prev      <= data_in;
                        r_match_cnt <= '0;
                        r_state     <= SYNC;
                    end
                end
                SYNC: begin
                    if (in_valid) begin
                        r_prev <= data_in;
                        if (w_match) begin
                            if (r_match_cnt == MW'(LOCK_CNT - 1)) begin
                                r_state    <= LOCKED;
                                r_miss_cnt <= '0;
                                locked     <= 1'b1;
                            end else begin
                                r_match_cnt <= r_match_cnt + MW'(1);
                            end
                        end else begin
                            r_match_cnt <= '0;
                            if (w_lockup) begin
                                r_state <= HUNT;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (in_valid) begin
                        // flywheel: predictor never re-seeds from received data
                        r_prev <= w_exp;
                        if (w_match) begin
                            r_miss_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            err_count <= w_err_inc;
`ifdef LFSR_CHK_BITERR_EN
                            bit_err_count <= w_bit_inc;
`endif
                            if (r_miss_cnt == LW'(LOSS_CNT - 1)) begin
                                r_state <= HUNT;
                                locked  <= 1'b0;
                            end else begin
                                r_miss_cnt <= r_miss_cnt + LW'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= HUNT;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side checker for the 20-bit PRBS pattern produced by the team's LFSR generator.
- Pattern rule: each word is the previous word shifted left one bit, with feedback ~(bit6 ^ bit19) inserted at bit 0.
- Block hunts for the pattern, locks after a run of consecutive matches, then free-runs its own predictor and counts mismatching words.
- Used on the FPGA interface path to validate the link carrying generator output.

Parameters:
- LOCK_CNT, 4: consecutive matching words required to enter LOCKED (min 1).
- LOSS_CNT, 3: consecutive mismatching words in LOCKED that force a return to HUNT (min 1).
- ERR_W, 16: width of the error counters.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- nreset, input, 1: synchronous, active-low reset.
- in_valid, input, 1: data_in carries a pattern word this cycle.
- data_in, input, 20: received pattern word.
- clear, input, 1: synchronous clear of err_count (and bit_err_count when built).
- locked, output, 1: high while state is LOCKED.
- err_pulse, output, 1: one-cycle pulse per mismatching word in LOCKED.
- err_count, output, ERR_W: saturating count of mismatching words.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - With nreset low at a clk edge: state=HUNT, prev=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0.
  - Reset mid-operation discards lock and counts immediately.
- Beats: only cycles with in_valid=1 are beats. Non-beat cycles change nothing except clear; err_pulse=0 on them.
- Predictor: exp = {prev[18:0], ~(prev[6]^prev[19])}.
- Forbidden word: 20'hFFFFF is the XNOR lockup state and is never accepted as a seed.
- HUNT:
  - Beat with data_in != 20'hFFFFF: prev<=data_in, match_cnt<=0, go to SYNC.
  - Beat with data_in == 20'hFFFFF: stay in HUNT.
- SYNC:
  - Beat with data_in==exp: match_cnt+1. When the count reaches LOCK_CNT, go to LOCKED with miss_cnt=0.
  - Beat with data_in!=exp: match_cnt<=0, stay in SYNC. Re-seeds, unless data_in==20'hFFFFF, in which case go to HUNT.
  - prev<=data_in on every SYNC beat.
  - No errors are counted in HUNT or SYNC.
- LOCKED (flywheel):
  - prev<=exp on every beat, regardless of data_in, so one corrupted word yields exactly one error.
  - Beat with data_in==exp: miss_cnt<=0.
  - Beat with data_in!=exp: err_pulse=1 next cycle, err_count+1 (saturates at all-ones), miss_cnt+1.
  - When miss_cnt reaches LOSS_CNT: go to HUNT, locked=0.
- Latency: all outputs are registered.
  - locked rises the cycle after the LOCK_CNT-th matching beat.
  - err_pulse and err_count update the cycle after the offending beat.
- clear with a simultaneous error: clear applies first and the error is counted, so err_count=1. clear does not affect state.
- State encoding: 2 bits, HUNT=0, SYNC=1, LOCKED=2. The unused code goes to HUNT on the next edge.

Optional Feature:
- Macro LFSR_CHK_BITERR_EN.
- Defined:
  - Adds output bit_err_count, ERR_W wide, saturating.
  - On each LOCKED mismatch beat it adds popcount(data_in ^ exp).
  - Cleared by reset and clear, with the same clear/simultaneous rule as err_count.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Lock: reset, then feed 0x00101, 0x00203, 0x00407, 0x0080F, 0x0101F on consecutive beats -> locked=1 the cycle after the 5th beat, err_count=0.
- Single error: while locked, send the next word 0x0203F as 0x0203E, then resume the correct sequence -> one err_pulse, err_count=1, locked stays 1, following words match. With LFSR_CHK_BITERR_EN, bit_err_count=1.
- Loss: while locked, send 3 consecutive words 0x00000 -> err_count=3, locked=0 the cycle after the 3rd, state HUNT. The sequence then relocks after LOCK_CNT+1 good beats.
- Lockup word: in HUNT, feed 0xFFFFF for 10 beats -> stays in HUNT, locked=0, no err_pulse.
- Gaps and clear: lock sequence with in_valid=0 for 1–3 cycles between beats -> still locks on the 5th beat. clear asserted in the same cycle as a locked mismatch with err_count=7 -> err_count=1.
- Reset mid-lock: nreset low for one edge while locked with err_count=5 -> next cycle locked=0, err_pulse=0, err_count=0, state HUNT.
